regbus2axi4lite: RTL and testbench

- Register-bus responder that converts one single-beat regbus request into a compliant AXI4-lite master transaction.
- Regbus masters (CSR sequencers, debug port) use it to reach AXI4-lite slaves on the SoC interconnect.
- Fully handshaked AXI4-lite master with a per-channel state machine, unlike a pass-through register stage.
- One transaction outstanding at a time.

---
 rtl/regbus2axi4lite_if.sv | 57 +++++
 rtl/regbus2axi4lite.sv | 231 +++++++++++++++++++++++
 tb/tb_regbus2axi4lite.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/regbus2axi4lite_if.sv
// Interface carrying the regbus request/response signals and the five
// AXI4-lite channels of regbus2axi4lite.
//   master : view of the bridge (regbus responder + AXI4-lite master)
//   slave  : view of the environment (regbus requester + AXI4-lite slave)
// Parameters: ADDR_W (address width), DATA_W (data width, multiple of 8).
interface regbus2axi4lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // regbus side
  logic                  addr_valid;
  logic                  reg_write;
  logic [ADDR_W-1:0]     reg_addr;
  logic [DATA_W-1:0]     reg_wdata;
  logic                  reg_ready;
  logic [DATA_W-1:0]     reg_rdata;
  logic                  reg_err;
  // AXI4-lite write channels
  logic                  awvalid;
  logic [ADDR_W-1:0]     awaddr;
  logic                  awready;
  logic                  wvalid;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wready;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic                  bready;
  // AXI4-lite read channels
  logic                  arvalid;
  logic [ADDR_W-1:0]     araddr;
  logic                  arready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rready;

  modport master (
    input  addr_valid, reg_write, reg_addr, reg_wdata,
    output reg_ready, reg_rdata, reg_err,
    output awvalid, awaddr, input awready,
    output wvalid, wdata, wstrb, input wready,
    input  bvalid, bresp, output bready,
    output arvalid, araddr, input arready,
    input  rvalid, rdata, rresp, output rready
  );

  modport slave (
    output addr_valid, reg_write, reg_addr, reg_wdata,
    input  reg_ready, reg_rdata, reg_err,
    input  awvalid, awaddr, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input  arvalid, araddr, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/regbus2axi4lite.sv
// regbus2axi4lite: accepts one single-beat regbus request at a time and
// issues it as a fully handshaked AXI4-lite master transaction. All outputs
// are registered.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (abandons any transaction)
//   bus   - regbus2axi4lite_if.master: regbus request/response + AXI4-lite
// Parameters: ADDR_W, DATA_W, TIMEOUT_CYCLES.
// Optional feature: define REGBUS2AXI_TIMEOUT_EN to add a watchdog that
// aborts a transaction after TIMEOUT_CYCLES busy cycles with reg_err=1.
//
// state   | meaning
// IDLE    | waiting for addr_valid
// WR      | AW and W channels in flight, each completes independently
// WR_RESP | waiting for the B response
// RD_ADDR | AR channel in flight
// RD_DATA | waiting for the R response
// DONE    | reg_ready pulse; no request is accepted here
module regbus2axi4lite #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst_n,
  regbus2axi4lite_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state_q, state_nxt;
  logic                awvalid_q, awvalid_nxt;
  logic                wvalid_q, wvalid_nxt;
  logic                bready_q, bready_nxt;
  logic                arvalid_q, arvalid_nxt;
  logic                rready_q, rready_nxt;
  logic                aw_done_q, aw_done_nxt;
  logic                w_done_q, w_done_nxt;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_nxt;
  logic [ADDR_W-1:0]   araddr_q, araddr_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic                reg_ready_q, reg_ready_nxt;
  logic [DATA_W-1:0]   reg_rdata_q, reg_rdata_nxt;
  logic                reg_err_q, reg_err_nxt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = awvalid_q & bus.awready;
  assign w_hs  = wvalid_q  & bus.wready;
  assign b_hs  = bready_q  & bus.bvalid;
  assign ar_hs = arvalid_q & bus.arready;
  assign r_hs  = rready_q  & bus.rvalid;

  // Only bit 1 of a response distinguishes error (SLVERR/DECERR) from success.
  logic unused_resp_lsb;
  assign unused_resp_lsb = bus.bresp[0] ^ bus.rresp[0];

`ifdef REGBUS2AXI_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] cnt_q, cnt_nxt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_nxt     = state_q;
    awvalid_nxt   = awvalid_q;
    wvalid_nxt    = wvalid_q;
    bready_nxt    = bready_q;
    arvalid_nxt   = arvalid_q;
    rready_nxt    = rready_q;
    aw_done_nxt   = aw_done_q;
    w_done_nxt    = w_done_q;
    awaddr_nxt    = awaddr_q;
    araddr_nxt    = araddr_q;
    wdata_nxt     = wdata_q;
    reg_ready_nxt = 1'b0;
    reg_rdata_nxt = reg_rdata_q;
    reg_err_nxt   = reg_err_q;
`ifdef REGBUS2AXI_TIMEOUT_EN
    cnt_nxt       = cnt_q + TO_W'(1);
`endif

    case (state_q)
      IDLE: begin
`ifdef REGBUS2AXI_TIMEOUT_EN
        cnt_nxt = '0;
`endif
        if (bus.addr_valid) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          if (bus.reg_write) begin
            state_nxt   = WR;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            awaddr_nxt  = bus.reg_addr;
            wdata_nxt   = bus.reg_wdata;
          end else begin
            state_nxt   = RD_ADDR;
            arvalid_nxt = 1'b1;
            araddr_nxt  = bus.reg_addr;
          end
        end
      end
      WR: begin
        if (aw_hs) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (w_hs) begin
          wvalid_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        // A handshake in this cycle counts as done so both channels may
        // finish together without an extra cycle.
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_nxt  = WR_RESP;
          bready_nxt = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          bready_nxt    = 1'b0;
          reg_err_nxt   = bus.bresp[1];
          reg_rdata_nxt = '0;
          reg_ready_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          rready_nxt    = 1'b0;
          reg_rdata_nxt = bus.rdata;
          reg_err_nxt   = bus.rresp[1];
          reg_ready_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

`ifdef REGBUS2AXI_TIMEOUT_EN
    // Watchdog abort overrides any handshake landing in the same cycle.
    if ((state_q != IDLE) && (state_q != DONE) &&
        (cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
      awvalid_nxt   = 1'b0;
      wvalid_nxt    = 1'b0;
      bready_nxt    = 1'b0;
      arvalid_nxt   = 1'b0;
      rready_nxt    = 1'b0;
      reg_err_nxt   = 1'b1;
      reg_rdata_nxt = '0;
      reg_ready_nxt = 1'b1;
      state_nxt     = DONE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      reg_ready_q <= 1'b0;
      reg_rdata_q <= '0;
      reg_err_q   <= 1'b0;
`ifdef REGBUS2AXI_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_nxt;
      awvalid_q   <= awvalid_nxt;
      wvalid_q    <= wvalid_nxt;
      bready_q    <= bready_nxt;
      arvalid_q   <= arvalid_nxt;
      rready_q    <= rready_nxt;
      aw_done_q   <= aw_done_nxt;
      w_done_q    <= w_done_nxt;
      awaddr_q    <= awaddr_nxt;
      araddr_q    <= araddr_nxt;
      wdata_q     <= wdata_nxt;
      reg_ready_q <= reg_ready_nxt;
      reg_rdata_q <= reg_rdata_nxt;
      reg_err_q   <= reg_err_nxt;
`ifdef REGBUS2AXI_TIMEOUT_EN
      cnt_q       <= cnt_nxt;
`endif
    end
  end

  assign bus.reg_ready = reg_ready_q;
  assign bus.reg_rdata = reg_rdata_q;
  assign bus.reg_err   = reg_err_q;
  assign bus.awvalid   = awvalid_q;
  assign bus.awaddr    = awaddr_q;
  assign bus.wvalid    = wvalid_q;
  assign bus.wdata     = wdata_q;
  assign bus.wstrb     = '1;
  assign bus.bready    = bready_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.araddr    = araddr_q;
  assign bus.rready    = rready_q;

endmodule

// File: tb/tb_regbus2axi4lite.sv
// Self-checking bench for regbus2axi4lite. A scripted AXI4-lite slave is
// described per transaction by a few delay numbers; the expected waveform of
// every DUT output is derived from those numbers as a cycle timeline.
// Cycle 0 is the first cycle after the clock edge that samples addr_valid.
module tb_regbus2axi4lite;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef REGBUS2AXI_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regbus2axi4lite_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regbus2axi4lite #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet_inputs();
    bus.addr_valid = 1'b0; bus.reg_write = 1'b0;
    bus.reg_addr = '0; bus.reg_wdata = '0;
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0;
    bus.rdata = '0; bus.rresp = 2'b00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".awvalid"}, bus.awvalid, 0);
    chk({tag, ".wvalid"}, bus.wvalid, 0);
    chk({tag, ".bready"}, bus.bready, 0);
    chk({tag, ".arvalid"}, bus.arvalid, 0);
    chk({tag, ".rready"}, bus.rready, 0);
    chk({tag, ".reg_ready"}, bus.reg_ready, 0);
    chk({tag, ".reg_err"}, bus.reg_err, 0);
    chk({tag, ".awaddr"}, bus.awaddr, 0);
    chk({tag, ".araddr"}, bus.araddr, 0);
    chk({tag, ".wdata"}, bus.wdata, 0);
    chk({tag, ".reg_rdata"}, bus.reg_rdata, 0);
    chk({tag, ".wstrb"}, bus.wstrb, {(DATA_W/8){1'b1}});
  endtask

  // Slave script: write -> awready from cycle a, wready from cycle w, bvalid
  // pulses in cycle max(a,w)+1+gap. Read -> arready from cycle a, rvalid pulses
  // in cycle a+1+gap. The unused response channel carries random stray valids.
  task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int a, input int w, input int gap, input logic [1:0] resp);
    int m, t_resp, t_done;
    bit e_awv, e_wv, e_br, e_arv, e_rr, e_rdy;
    string tg;
    m      = wr ? ((a > w) ? a : w) : a;
    t_resp = m + 1 + gap;
    t_done = t_resp + 1;
    @(negedge clk);
    quiet_inputs();
    bus.addr_valid = 1'b1; bus.reg_write = wr;
    bus.reg_addr = addr; bus.reg_wdata = wd;
    for (int k = 0; k <= t_done + 1; k++) begin
      @(negedge clk);
      tg    = $sformatf("%s@%0d", name, k);
      e_awv = wr && (k <= a);
      e_wv  = wr && (k <= w);
      e_br  = wr && (k >= m + 1) && (k <= t_resp);
      e_arv = !wr && (k <= a);
      e_rr  = !wr && (k >= a + 1) && (k <= t_resp);
      e_rdy = (k == t_done);
      chk({tg, ".awvalid"}, bus.awvalid, e_awv);
      chk({tg, ".wvalid"}, bus.wvalid, e_wv);
      chk({tg, ".bready"}, bus.bready, e_br);
      chk({tg, ".arvalid"}, bus.arvalid, e_arv);
      chk({tg, ".rready"}, bus.rready, e_rr);
      chk({tg, ".reg_ready"}, bus.reg_ready, e_rdy);
      if (e_awv) chk({tg, ".awaddr"}, bus.awaddr, addr);
      if (e_wv) begin
        chk({tg, ".wdata"}, bus.wdata, wd);
        chk({tg, ".wstrb"}, bus.wstrb, {(DATA_W/8){1'b1}});
      end
      if (e_arv) chk({tg, ".araddr"}, bus.araddr, addr);
      if (e_rdy) begin
        chk({tg, ".reg_err"}, bus.reg_err, resp[1]);
        chk({tg, ".reg_rdata"}, bus.reg_rdata, wr ? 32'h0 : rd);
      end
      // inputs for cycle k
      bus.addr_valid = (k <= t_done);
      bus.awready = wr && (k >= a);
      bus.wready  = wr && (k >= w);
      bus.arready = !wr && (k >= a);
      bus.bvalid  = wr ? (k == t_resp) : 1'($urandom_range(0, 1));
      bus.rvalid  = !wr ? (k == t_resp) : 1'($urandom_range(0, 1));
      bus.bresp   = (wr && k == t_resp) ? resp : 2'($urandom_range(0, 3));
      bus.rresp   = (!wr && k == t_resp) ? resp : 2'($urandom_range(0, 3));
      bus.rdata   = (!wr && k == t_resp) ? rd : $urandom();
    end
  endtask

  initial begin
    quiet_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_reset_idle");

    // Zero-wait write: reg_ready in cycle 2 (the 4th cycle counting the
    // request sample cycle as the 1st).
    run_txn("wr_zero_wait", 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 2'b00);
    run_txn("rd_waits", 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 3, 0, 2, 2'b00);
    run_txn("wr_w_before_aw", 1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 32'h0, 5, 0, 1, 2'b00);
    run_txn("wr_aw_before_w", 1'b1, 32'h0000_0048, 32'h0F0F_F0F0, 32'h0, 0, 4, 0, 2'b01);
    run_txn("rd_slverr", 1'b0, 32'h0000_0030, 32'h0, 32'hDEAD_BEEF, 1, 0, 1, 2'b10);
    run_txn("wr_decerr", 1'b1, 32'h0000_0034, 32'h1111_2222, 32'h0, 1, 1, 0, 2'b11);
    run_txn("rd_exokay", 1'b0, 32'h0000_0038, 32'h0, 32'h7777_8888, 0, 0, 0, 2'b01);

    // Reset while waiting in WR_RESP with bvalid pending.
    @(negedge clk);
    quiet_inputs();
    bus.addr_valid = 1'b1; bus.reg_write = 1'b1;
    bus.reg_addr = 32'h0000_0050; bus.reg_wdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.awready = 1'b1; bus.wready = 1'b1;
    @(negedge clk);
    chk("rst_mid.bready_before", bus.bready, 1);
    bus.bvalid = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid");
    quiet_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid_idle");
    run_txn("after_rst", 1'b1, 32'h0000_0054, 32'h9876_5432, 32'h0, 0, 0, 0, 2'b00);

    for (int i = 0; i < 24; i++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      run_txn($sformatf("rand%0d", i), wr, $urandom(), $urandom(), $urandom(),
              $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3),
              2'($urandom_range(0, 3)));
    end

`ifdef REGBUS2AXI_TIMEOUT_EN
    // Slave never accepts AR: abort after TO busy cycles.
    @(negedge clk);
    quiet_inputs();
    bus.addr_valid = 1'b1; bus.reg_write = 1'b0; bus.reg_addr = 32'h0000_0060;
    for (int k = 0; k <= TO + 1; k++) begin
      @(negedge clk);
      chk($sformatf("timeout@%0d.arvalid", k), bus.arvalid, k <= TO - 1);
      chk($sformatf("timeout@%0d.reg_ready", k), bus.reg_ready, k == TO);
      if (k == TO) begin
        chk("timeout.reg_err", bus.reg_err, 1);
        chk("timeout.reg_rdata", bus.reg_rdata, 0);
      end
      bus.addr_valid = (k <= TO);
    end
    run_txn("after_timeout", 1'b0, 32'h0000_0064, 32'h0, 32'hFACE_B00C, 0, 0, 0, 2'b00);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
